johnson_seq_monitor: RTL and testbench
======================================

# johnson_seq_monitor

Downstream consumer of the 4-bit Johnson counter. Samples the counter's `count` bus every clock, decodes it to a phase index and checks legality and sequencing. Once a clean run is seen it declares lock, emits a wrap strobe once per revolution and counts errors. It sits between the counter and any logic that needs phase strobes or a counter-health indication.

## Interface
Parameters:
- `WIDTH`, default 4: Johnson register width. The counter has 2*WIDTH states.
- `LOCK_CNT`, default 3: consecutive in-sequence legal codes required to lock. Range 1..2*WIDTH.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `count_in` in WIDTH: Johnson code from the upstream counter.
- `phase` out $clog2(2*WIDTH): decoded phase index.
- `phase_valid` out 1: `count_in` was a legal code at the last edge.
- `locked` out 1: sequence lock achieved.
- `wrap` out 1: one-cycle pulse on phase 2*WIDTH-1 → 0 while locked.
- `err` out 1: one-cycle pulse when an error is detected.
- `err_count` out ERR_W: saturating error total.

## Operation
- Legal sequence (WIDTH=4): 0000→1000→1100→1110→1111→0111→0011→0001→0000. This corresponds to the counter's next state `{~q[0], q[W-1:1]}`.
- Phase decode:
  - k ones packed from the MSB gives phase k, for k = 0..W.
  - m zeros packed from the MSB followed by all ones gives phase W+m, for m = 1..W-1.
  - Any other code is illegal: `phase_valid`=0 and `phase` holds its previous value.
- Internal state: `prev_phase`, `prev_ok`, run counter `run`, FSM state `SEARCH` or `LOCKED`.
- A code is a successor when `prev_ok` is set and phase == (`prev_phase`+1) mod 2W.
- SEARCH:
  - Successor: `run`+1.
  - Legal but not a successor: `run`=1.
  - Illegal: `run`=0 and `err` pulses.
  - When `run` reaches LOCK_CNT, go to LOCKED and set `locked` at that same edge.
- LOCKED:
  - Successor: stay locked. `wrap` pulses if the phase went 2W-1→0.
  - Illegal code, or a legal non-successor: `err` pulses, go to SEARCH, `locked`=0. `run`=1 if the code was legal, otherwise 0.
- `err_count` increments on every `err` pulse and saturates at 2^ERR_W-1.
- `prev_ok` takes the value of `phase_valid`. `prev_phase` updates only on a legal code.

## Timing
- All outputs are registered. They reflect the `count_in` sampled at that same rising edge, so latency is one edge from input to output.
- Reset values: `phase`=0, `phase_valid`=0, `locked`=0, `wrap`=0, `err`=0, `err_count`=0. FSM=SEARCH, `run`=0, `prev_ok`=0.
- First edge after reset: there is no predecessor, so a legal code gives `run`=1 and never raises `err`.
- Asserting `rst` mid-lock clears everything at the next edge. `count_in` is ignored while `rst` is high.
- `wrap` and `err` cannot assert together. `err` takes precedence, so `wrap` is suppressed on that edge.
- With LOCK_CNT=1, lock is declared on the first legal code.
- Lock re-acquisition after an error with a legal code takes LOCK_CNT-1 further successor edges.

## Configuration
- `JOHNSON_MON_HOLD_EN` defined: a legal code equal to `prev_phase` counts as a hold.
  - In LOCKED: no error, no `wrap`, `run` unchanged, stays locked.
  - In SEARCH: `run` unchanged.
  - This supports an upstream counter that has an enable.
- `JOHNSON_MON_HOLD_EN` undefined: a repeated code is a non-successor. It is an error in LOCKED and resets `run` to 1 in SEARCH.

## Structure
- Package `johnson_pkg` holds:
  - the FSM state typedef (`SEARCH`, `LOCKED`);
  - the default WIDTH constant;
  - the phase-width helper constant.
- Sub-module `johnson_decode` is purely combinational: `count_in` → {`legal`, `phase`}, parameterised by WIDTH.
- The top level holds the registers, the FSM and the counters.

## Test plan
All scenarios use WIDTH=4 and LOCK_CNT=3.
1. Reset, then drive 0000,1000,1100 → `locked`=1 at the third edge, `phase`=2, `err`=0, `err_count`=0.
2. Locked, drive through 0011,0001,0000 → `wrap`=1 only on the 0000 edge with `phase`=0. `locked` stays 1.
3. Locked at 1100, inject 1010 → `err`=1 for one cycle, `phase_valid`=0, `locked`=0, `err_count`=1, `phase` holds 2.
4. Locked at 1100, skip to 1111 → `err` pulses and `locked`=0. Then 0111,0011 → `locked`=1 again at the 0011 edge.
5. Locked, hold 1110 for two edges → without the macro: `err`=1 and `err_count`+1. With `JOHNSON_MON_HOLD_EN`: no `err`, `locked` stays 1.
6. 300 consecutive illegal 0101 codes → `err_count`=255 (saturated). Then assert `rst` for one edge → all outputs 0 at the next edge.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson counter sequence monitor.
package johnson_pkg;

  // Default Johnson register width; the counter then has 2*WIDTH states.
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Bits needed to hold a phase index 0..2*w-1.
  function automatic int unsigned phase_w(input int unsigned w);
    return (w < 1) ? 1 : $clog2(2 * w);
  endfunction

  localparam int unsigned DEFAULT_PHASE_W = phase_w(DEFAULT_WIDTH);

  // Sequence tracker state.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } mon_state_e;

endpackage : johnson_pkg

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: maps a code to its phase index and
// flags codes that never appear in a healthy Johnson sequence.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]              count_in,
  output logic                          legal,
  output logic [phase_w(WIDTH)-1:0]     phase
);

  localparam int unsigned PW = phase_w(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Match against the filling half (ones from the MSB) and the draining half
  // (zeros from the MSB followed by ones); the patterns are all distinct.
  always_comb begin
    legal = 1'b0;
    phase = '0;
    for (int unsigned k = 0; k <= WIDTH; k++) begin
      if (count_in == ~(ALL_ONES >> k)) begin
        legal = 1'b1;
        phase = PW'(k);
      end
    end
    for (int unsigned m = 1; m < WIDTH; m++) begin
      if (count_in == (ALL_ONES >> m)) begin
        legal = 1'b1;
        phase = PW'(WIDTH + m);
      end
    end
  end

endmodule : johnson_decode

// File: rtl/johnson_seq_monitor.sv
// Johnson counter sequence monitor: decodes the upstream count, tracks
// sequencing, declares lock, emits a per-revolution wrap strobe and keeps a
// saturating error total.
// Optional build macro: JOHNSON_MON_HOLD_EN -- a repeated legal code is
// treated as a hold (upstream counter with enable) instead of an error.
module johnson_seq_monitor
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          count_in,
  output logic [phase_w(WIDTH)-1:0] phase,
  output logic                      phase_valid,
  output logic                      locked,
  output logic                      wrap,
  output logic                      err,
  output logic [ERR_W-1:0]          err_count
);

  localparam int unsigned PW    = phase_w(WIDTH);
  localparam int unsigned NPH   = 2 * WIDTH;
  localparam int unsigned RUN_W = $clog2(NPH + 1);

  localparam logic [PW-1:0]    LAST_PHASE = PW'(NPH - 1);
  localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  logic              dec_legal;
  logic [PW-1:0]     dec_phase;

  mon_state_e        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;

  // phase_q doubles as the previous legal phase and phase_valid_q as the
  // "previous code was legal" flag: both update under exactly those rules.
  logic [PW-1:0]     phase_q;
  logic              phase_valid_q;
  logic              locked_q;
  logic              wrap_q;
  logic              err_q;
  logic [ERR_W-1:0]  err_count_q;

  logic [PW-1:0]     exp_phase;
  logic              is_succ;
  logic              is_hold;
  logic              err_d;
  logic              wrap_d;

  johnson_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .count_in (count_in),
    .legal    (dec_legal),
    .phase    (dec_phase)
  );

  // Classify the current code relative to the previous legal phase.
  always_comb begin
    exp_phase = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
    is_succ   = phase_valid_q && dec_legal && (dec_phase == exp_phase);
`ifdef JOHNSON_MON_HOLD_EN
    is_hold   = phase_valid_q && dec_legal && (dec_phase == phase_q);
`else
    is_hold   = 1'b0;
`endif
  end

  // Next-state, run counter and strobe decisions.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (!dec_legal) begin
          run_d = '0;
          err_d = 1'b1;
        end else if (is_hold) begin
          run_d = run_q;
        end else if (is_succ) begin
          run_d = run_q + RUN_W'(1);
        end else begin
          run_d = RUN_W'(1);
        end
        if (dec_legal && (run_d >= LOCK_RUN)) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (is_hold) begin
          run_d = run_q;
        end else if (is_succ) begin
          wrap_d = (phase_q == LAST_PHASE) && (dec_phase == '0);
        end else begin
          err_d   = 1'b1;
          state_d = SEARCH;
          run_d   = dec_legal ? RUN_W'(1) : '0;
        end
      end
      default: begin
        state_d = SEARCH;
        run_d   = '0;
      end
    endcase
  end

  // FSM state and run counter registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= SEARCH;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Registered outputs; phase holds its last legal value across bad codes.
  always_ff @(posedge clock) begin
    if (rst) begin
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      wrap_q        <= 1'b0;
      err_q         <= 1'b0;
      err_count_q   <= '0;
    end else begin
      if (dec_legal) begin
        phase_q <= dec_phase;
      end
      phase_valid_q <= dec_legal;
      locked_q      <= (state_d == LOCKED);
      wrap_q        <= wrap_d;
      err_q         <= err_d;
      if (err_d && (err_count_q != ERR_MAX)) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = locked_q;
  assign wrap        = wrap_q;
  assign err         = err_q;
  assign err_count   = err_count_q;

endmodule : johnson_seq_monitor

// File: tb/tb_johnson_seq_monitor.sv
// Self-checking bench for johnson_seq_monitor (WIDTH=4, LOCK_CNT=3, ERR_W=8).
// Expectations follow the JOHNSON_MON_HOLD_EN setting of the build.
module tb_johnson_seq_monitor;

  logic       clock;
  logic       rst;
  logic [3:0] count_in;
  logic [2:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       wrap;
  logic       err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic [3:0] cin;
    logic [2:0] ph;
    logic       pv;
    logic       lk;
    logic       wr;
    logic       er;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  johnson_seq_monitor #(
    .WIDTH    (4),
    .LOCK_CNT (3),
    .ERR_W    (8)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .count_in    (count_in),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .wrap        (wrap),
    .err         (err),
    .err_count   (err_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic add(input logic r, input logic [3:0] cin, input logic [2:0] ph,
                     input logic pv, input logic lk, input logic wr,
                     input logic er, input logic [7:0] ec);
    vec_t v;
    v.r = r; v.cin = cin; v.ph = ph; v.pv = pv; v.lk = lk; v.wr = wr; v.er = er; v.ec = ec;
    tbl.push_back(v);
  endtask

  // Apply one input edge and compare all outputs against the expectation.
  task automatic step_check(input string name, input vec_t v);
    rst      = v.r;
    count_in = v.cin;
    @(posedge clock);
    #1;
    checks++;
    if (phase !== v.ph || phase_valid !== v.pv || locked !== v.lk ||
        wrap !== v.wr || err !== v.er || err_count !== v.ec) begin
      errors++;
      $display("FAIL %s: got phase=%0d pv=%b locked=%b wrap=%b err=%b err_count=%0d, expected phase=%0d pv=%b locked=%b wrap=%b err=%b err_count=%0d",
               name, phase, phase_valid, locked, wrap, err, err_count,
               v.ph, v.pv, v.lk, v.wr, v.er, v.ec);
    end
  endtask

  initial begin
    vec_t v;
    rst      = 1'b1;
    count_in = 4'b0000;

    //  rst cin      ph pv lk wr er ec
    add(1, 4'b0101, 0, 0, 0, 0, 0, 0);   // reset state
    add(0, 4'b0000, 0, 1, 0, 0, 0, 0);   // first code after reset: run=1, no err
    add(0, 4'b1000, 1, 1, 0, 0, 0, 0);
    add(0, 4'b1100, 2, 1, 1, 0, 0, 0);   // lock on third in-sequence edge
    add(0, 4'b1110, 3, 1, 1, 0, 0, 0);
    add(0, 4'b1111, 4, 1, 1, 0, 0, 0);
    add(0, 4'b0111, 5, 1, 1, 0, 0, 0);
    add(0, 4'b0011, 6, 1, 1, 0, 0, 0);
    add(0, 4'b0001, 7, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 0);   // wrap 7->0
    add(0, 4'b1000, 1, 1, 1, 0, 0, 0);   // wrap is a single pulse
    add(0, 4'b1100, 2, 1, 1, 0, 0, 0);
    add(0, 4'b1010, 2, 0, 0, 0, 1, 1);   // illegal while locked, phase holds
    add(0, 4'b1100, 2, 1, 0, 0, 0, 1);   // no predecessor: run=1
    add(0, 4'b1110, 3, 1, 0, 0, 0, 1);
    add(0, 4'b1111, 4, 1, 1, 0, 0, 1);   // relocked
    add(0, 4'b0111, 5, 1, 1, 0, 0, 1);
    add(0, 4'b0011, 6, 1, 1, 0, 0, 1);
    add(0, 4'b0001, 7, 1, 1, 0, 0, 1);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 1);
    add(0, 4'b1000, 1, 1, 1, 0, 0, 1);
    add(0, 4'b1100, 2, 1, 1, 0, 0, 1);
    add(0, 4'b1111, 4, 1, 0, 0, 1, 2);   // skip 2->4: err, unlock, run=1
    add(0, 4'b0111, 5, 1, 0, 0, 0, 2);
    add(0, 4'b0011, 6, 1, 1, 0, 0, 2);   // relock after LOCK_CNT-1 successors
    add(0, 4'b0001, 7, 1, 1, 0, 0, 2);
    add(0, 4'b0000, 0, 1, 1, 1, 0, 2);
    add(0, 4'b1000, 1, 1, 1, 0, 0, 2);
    add(0, 4'b1100, 2, 1, 1, 0, 0, 2);
    add(0, 4'b1110, 3, 1, 1, 0, 0, 2);
`ifdef JOHNSON_MON_HOLD_EN
    add(0, 4'b1110, 3, 1, 1, 0, 0, 2);   // hold: no err, stays locked
    add(0, 4'b1111, 4, 1, 1, 0, 0, 2);
    add(0, 4'b0111, 5, 1, 1, 0, 0, 2);
    add(0, 4'b0011, 6, 1, 1, 0, 0, 2);
    add(0, 4'b0001, 7, 1, 1, 0, 0, 2);
    add(0, 4'b1000, 1, 1, 0, 0, 1, 3);   // 7->1 while locked: err, no wrap
    add(0, 4'b1010, 1, 0, 0, 0, 1, 4);   // illegal in SEARCH
`else
    add(0, 4'b1110, 3, 1, 0, 0, 1, 3);   // repeat: err, unlock, run=1
    add(0, 4'b1111, 4, 1, 0, 0, 0, 3);
    add(0, 4'b0111, 5, 1, 1, 0, 0, 3);
    add(0, 4'b0011, 6, 1, 1, 0, 0, 3);
    add(0, 4'b0001, 7, 1, 1, 0, 0, 3);
    add(0, 4'b1000, 1, 1, 0, 0, 1, 4);   // 7->1 while locked: err, no wrap
    add(0, 4'b1010, 1, 0, 0, 0, 1, 5);   // illegal in SEARCH
`endif
    add(0, 4'b0000, 0, 1, 0, 0, 0, tbl[tbl.size()-1].ec); // legal after illegal: no wrap, no err

    for (int i = 0; i < tbl.size(); i++) begin
      step_check($sformatf("vec%0d", i), tbl[i]);
    end

    // Long run of illegal codes: error counter saturates at 255.
    rst      = 1'b0;
    count_in = 4'b0101;
    for (int i = 0; i < 299; i++) begin
      @(posedge clock);
    end
    #1;
    v = '{r: 1'b0, cin: 4'b0101, ph: 3'd0, pv: 1'b0, lk: 1'b0, wr: 1'b0, er: 1'b1, ec: 8'd255};
    step_check("saturate", v);
    v = '{r: 1'b0, cin: 4'b1010, ph: 3'd0, pv: 1'b0, lk: 1'b0, wr: 1'b0, er: 1'b1, ec: 8'd255};
    step_check("saturate_hold", v);

    // Reset clears everything on the next edge regardless of count_in.
    v = '{r: 1'b1, cin: 4'b1000, ph: 3'd0, pv: 1'b0, lk: 1'b0, wr: 1'b0, er: 1'b0, ec: 8'd0};
    step_check("reset_clear", v);
    v = '{r: 1'b0, cin: 4'b0011, ph: 3'd6, pv: 1'b1, lk: 1'b0, wr: 1'b0, er: 1'b0, ec: 8'd0};
    step_check("post_reset_first", v);
    v = '{r: 1'b0, cin: 4'b0001, ph: 3'd7, pv: 1'b1, lk: 1'b0, wr: 1'b0, er: 1'b0, ec: 8'd0};
    step_check("post_reset_second", v);
    v = '{r: 1'b0, cin: 4'b0000, ph: 3'd0, pv: 1'b1, lk: 1'b1, wr: 1'b0, er: 1'b0, ec: 8'd0};
    step_check("lock_at_wrap_no_strobe", v);
    v = '{r: 1'b0, cin: 4'b1000, ph: 3'd1, pv: 1'b1, lk: 1'b1, wr: 1'b0, er: 1'b0, ec: 8'd0};
    step_check("locked_continue", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_johnson_seq_monitor
